// File: rtl/muller_c_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muller_c_sched - round-robin arbiter and four-phase sequencer for one shared
// Muller C-element channel, with timeout and handshake counter.  Rev 1.0
// ---------------------------------------------------------------------------
module muller_c_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic             c_a,
  output logic             c_b,
  input  logic             c_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] hs_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RISE = 3'd1,
    S_FALL = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              meta_q;
  logic              q_s_q;
  logic [NREQ-1:0]   req_q;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  gidx_q, gidx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              c_a_q, c_a_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  hs_count_q, hs_count_d;

  logic              win_found;
  logic [PTR_W-1:0]  win_idx;

  // (base + off) mod NREQ, valid for base < NREQ and off < NREQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[PTR_W-1:0];
  endfunction

  // Scan from highest to lowest offset so the nearest requester to ptr wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_q[wrap_add(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    timer_d    = timer_q;
    hs_count_d = hs_count_q;

    case (state_q)
      S_IDLE: begin
        // A high q_s means the channel is not quiescent yet
        if (win_found && !q_s_q) begin
          gidx_d  = win_idx;
          timer_d = '0;
          state_d = S_RISE;
        end
      end
      S_RISE: begin
        if (q_s_q) begin
          timer_d = '0;
          state_d = S_FALL;
        end else if (timer_q == TMR_MAX) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FALL: begin
        if (!q_s_q) begin
          state_d    = S_DONE;
          hs_count_d = hs_count_q + 1'b1;
        end else if (timer_q == TMR_MAX) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = wrap_add(gidx_q, 1);
        state_d = S_IDLE;
      end
      S_ERR: begin
        ptr_d   = wrap_add(gidx_q, 1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the next state so they change on the transition edge
    grant_d = '0;
    if (state_d != S_IDLE) grant_d[gidx_d] = 1'b1;
    c_a_d  = (state_d == S_RISE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      meta_q     <= 1'b0;
      q_s_q      <= 1'b0;
      req_q      <= '0;
      ptr_q      <= '0;
      gidx_q     <= '0;
      timer_q    <= '0;
      grant_q    <= '0;
      c_a_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hs_count_q <= '0;
    end else begin
      state_q    <= state_d;
      meta_q     <= c_q;
      q_s_q      <= meta_q;
      req_q      <= req;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      timer_q    <= timer_d;
      grant_q    <= grant_d;
      c_a_q      <= c_a_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hs_count_q <= hs_count_d;
    end
  end

  assign grant    = grant_q;
  assign c_a      = c_a_q;
  assign c_b      = c_a_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign hs_count = hs_count_q;

endmodule
`default_nettype wire

// File: tb/tb_muller_c_sched.sv
`default_nettype none
// tb_muller_c_sched - scoreboard bench: expected grant/outcome/count pushed when
// requests are driven, popped on each done/err pulse.
module tb_muller_c_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic             c_q = 1'b0;
  logic [NREQ-1:0]  grant;
  logic             c_a, c_b, busy, done, err;
  logic [CNT_W-1:0] hs_count;

  muller_c_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .grant    (grant),
    .c_a      (c_a),
    .c_b      (c_b),
    .c_q      (c_q),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .hs_count (hs_count)
  );

  always #5 clock = ~clock;

  // Element model: 0 = ideal (one-cycle delay), 1 = stuck low, 2 = latches high once risen
  int el_mode = 0;
  always @(posedge clock) begin
    case (el_mode)
      0:       c_q <= c_a;
      1:       c_q <= 1'b0;
      default: c_q <= c_q | c_a;
    endcase
  end

  typedef struct packed {
    logic [NREQ-1:0]  grant;
    logic             is_err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tb_ptr = 0;
  int   tb_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx, input bit is_err);
    exp_t e;
    if (!is_err) tb_cnt++;
    e.grant      = '0;
    e.grant[idx] = 1'b1;
    e.is_err     = is_err;
    e.cnt        = CNT_W'(tb_cnt);
    sb.push_back(e);
    tb_ptr = (idx + 1) % NREQ;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_busy(input int budget);
    int k = 0;
    while (!busy && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("wait_busy", busy, 1);
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (reset_n && (done || err)) begin
      check("done_err_excl", done & err, 0);
      if (sb.size() == 0) begin
        check("sb_unexpected_evt", {done, err}, 0);
      end else begin
        e = sb.pop_front();
        check("sb_grant", grant, e.grant);
        check("sb_err", err, e.is_err);
        check("sb_count", hs_count, e.cnt);
        check("sb_ca_low", c_a, 0);
        check("sb_cb_eq_ca", c_b, c_a);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin : stim
    int k, w, w1, w2;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_grant", grant, 0);
    check("rst_ca", c_a, 0);
    check("rst_cb", c_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", hs_count, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // All four requesting continuously: strict rotation from ptr 0
    el_mode = 0;
    for (int i = 0; i < 8; i++) push_exp(tb_ptr, 1'b0);
    req = '1;
    wait_drain(200);
    req = '0;
    check("hs_after_8", hs_count, 8);
    repeat (3) @(negedge clock);

    // Single requester: grant at sample edge + 1, done at sample edge + 9
    push_exp(0, 1'b0);
    req = 4'b0001;
    k = 0;
    while (!done && k < 30) begin
      @(negedge clock);
      k++;
      if (k == 1) check("lat_grant_early", grant, 0);
      if (k == 2) begin
        check("lat_grant", grant, 4'b0001);
        check("lat_ca", c_a, 1);
        check("lat_busy", busy, 1);
      end
    end
    check("done_latency", k, 10);
    req = '0;
    wait_drain(20);
    repeat (2) @(negedge clock);

    // Requester drops req mid-handshake: sequence still completes
    push_exp(2, 1'b0);
    req = 4'b0100;
    wait_busy(10);
    req = '0;
    wait_drain(30);
    check("drop_ca_low", c_a, 0);
    repeat (2) @(negedge clock);

    // Stuck-low element: RISE times out, next requester served normally
    w1 = tb_ptr;
    w2 = (tb_ptr + 1) % NREQ;
    el_mode = 1;
    push_exp(w1, 1'b1);
    push_exp(w2, 1'b0);
    req = '0;
    req[w1] = 1'b1;
    req[w2] = 1'b1;
    wait_busy(10);
    k = 0;
    while (!err && k < 40) begin
      @(negedge clock);
      k++;
    end
    check("rise_timeout_lat", k, TIMEOUT + 1);
    el_mode = 0;
    req[w1] = 1'b0;
    @(negedge clock);
    check("grant_after_err", grant, 0);
    wait_drain(40);
    req = '0;
    repeat (2) @(negedge clock);

    // Stuck-high element: FALL times out, IDLE holds off while q_s = 1
    w  = tb_ptr;
    w2 = (tb_ptr + 1) % NREQ;
    el_mode = 2;
    push_exp(w, 1'b1);
    push_exp(w2, 1'b0);
    req = '0;
    req[w] = 1'b1;
    k = 0;
    while (!err && k < 80) begin
      @(negedge clock);
      k++;
    end
    check("fall_timeout_seen", err, 1);
    req = '0;
    req[w2] = 1'b1;
    repeat (10) @(negedge clock);
    check("hold_busy", busy, 0);
    check("hold_grant", grant, 0);
    el_mode = 0;
    wait_drain(40);
    req = '0;
    repeat (2) @(negedge clock);

    // Async reset while in RISE
    el_mode = 1;
    w = tb_ptr;
    req = '0;
    req[w] = 1'b1;
    wait_busy(10);
    repeat (3) @(negedge clock);
    check("arst_pre_ca", c_a, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ca", c_a, 0);
    check("arst_cb", c_b, 0);
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    check("arst_count", hs_count, 0);
    @(negedge clock);
    req = '0;
    @(negedge clock);
    reset_n = 1'b1;
    tb_cnt = 0;
    tb_ptr = 0;
    el_mode = 0;
    repeat (3) @(negedge clock);
    check("arst_idle_busy", busy, 0);
    check("arst_idle_count", hs_count, 0);

    // Counter wrap at 2^CNT_W: 16th handshake reads 0, 17th reads 1
    for (int i = 0; i < 17; i++) push_exp(tb_ptr, 1'b0);
    req = '1;
    wait_drain(400);
    req = '0;
    check("wrap_final", hs_count, 1);
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
